alu_issue: RTL and testbench

Issue stage that drives the ALU's operation-select interface. It accepts a decoded instruction beat (ALUOp class plus funct field and two operands) on a valid/ready handshake and encodes it into the 3-bit ALU control code. It registers code and operands toward the ALU and enforces the multi-cycle occupancy of MUL by stalling further issue. It sits between the ID/EX boundary and the ALU, and is the single producer of the ALU control code.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_ctrl_dec.sv | 32 +++
 rtl/alu_issue.sv | 141 ++++++++++++++
 tb/tb_alu_issue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALUOp classes and R-type funct values.
// Imported by the issue stage, its decoder and the ALU itself.
package alu_pkg;

    localparam int ALU_CODE_W  = 3;
    localparam int STALL_CNT_W = 4;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decode into the 3-bit ALU control code.
// Undecodable combinations fall back to ADD and raise the illegal flag.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0]            aluop,
    input  logic [5:0]            funct,
    output logic [ALU_CODE_W-1:0] code,
    output logic                  illegal
);

    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_MUL: code = ALU_MUL;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: one-entry output register with valid/ready handshake and MUL occupancy stall.
// Define ALU_ISSUE_ILLEGAL_EN to register and expose the illegal-op flag on illegal_o.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | output register empty, ready for a beat
// ST_HOLD    | output register holds a valid beat
// ST_MULWAIT | ALU busy with a MUL, stall counter running
module alu_issue
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            aluop_i,
    input  logic [5:0]            funct_i,
    input  logic [31:0]           data0_i,
    input  logic [31:0]           data1_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ALU_CODE_W-1:0] aluctrl_o,
    output logic [31:0]           data0_o,
    output logic [31:0]           data1_o,
    output logic                  busy_o,
    output logic                  illegal_o
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_issue: MUL_LAT must be within 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_MULWAIT = 2'd2
    } state_t;

    localparam bit                     MUL_STALLS    = (MUL_LAT > 1);
    localparam logic [STALL_CNT_W-1:0] MUL_WAIT_INIT = STALL_CNT_W'(MUL_LAT - 1);

    state_t                 state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [ALU_CODE_W-1:0]  dec_code;
    logic                   dec_illegal;
    logic                   accept, consume, mul_out;

    alu_ctrl_dec u_dec (
        .aluop   (aluop_i),
        .funct   (funct_i),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    assign accept  = in_valid_i & in_ready_o;
    assign consume = out_valid_o & out_ready_i;
    assign mul_out = (aluctrl_o == ALU_MUL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (consume) begin
                    if (mul_out) begin
                        if (MUL_STALLS) begin
                            state_d = ST_MULWAIT;
                            cnt_d   = MUL_WAIT_INIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (accept) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MULWAIT: begin
                cnt_d = cnt_q - 1'b1;
                // <=1 also recovers cleanly should the counter ever hold 0 here
                if (cnt_q <= 1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_o = (state_q == ST_HOLD);
        busy_o      = (state_q == ST_MULWAIT);
        // a MUL on its consume edge blocks issue so the stall starts clean
        in_ready_o  = (state_q == ST_IDLE) |
                      ((state_q == ST_HOLD) & out_ready_i & ~mul_out);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aluctrl_o <= ALU_ADD;
            data0_o   <= '0;
            data1_o   <= '0;
        end else if (accept) begin
            aluctrl_o <= dec_code;
            data0_o   <= data0_i;
            data1_o   <= data1_i;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= dec_illegal;
        end
    end

    assign illegal_o = illegal_q & out_valid_o;
`else
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
    assign illegal_o          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (MUL_LAT=3 and MUL_LAT=1) share one random/directed
// stimulus stream and are compared every cycle against a beat/stall-count reference model.
module tb_alu_issue;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  aluop = 2'b00;
    logic [5:0]  funct = 6'b0;
    logic [31:0] d0_in = '0;
    logic [31:0] d1_in = '0;

    logic [1:0]        rdy, ov, bsy, ill;
    logic [1:0][2:0]   ctrl;
    logic [1:0][31:0]  q0, q1;

    int checks = 0;
    int failures = 0;

    // reference model: one optional beat plus a count of remaining MUL stall cycles
    bit        m_v[2];
    bit [2:0]  m_code[2];
    bit [31:0] m_d0[2];
    bit [31:0] m_d1[2];
    bit        m_il[2];
    int        m_stall[2];
    int        lat[2];

    always #5 clk = ~clk;

    alu_issue #(.MUL_LAT(LAT0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
        .aluop_i(aluop), .funct_i(funct), .data0_i(d0_in), .data1_i(d1_in),
        .out_valid_o(ov[0]), .out_ready_i(out_ready), .aluctrl_o(ctrl[0]),
        .data0_o(q0[0]), .data1_o(q1[0]), .busy_o(bsy[0]), .illegal_o(ill[0])
    );

    alu_issue #(.MUL_LAT(LAT1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
        .aluop_i(aluop), .funct_i(funct), .data0_i(d0_in), .data1_i(d1_in),
        .out_valid_o(ov[1]), .out_ready_i(out_ready), .aluctrl_o(ctrl[1]),
        .data0_o(q0[1]), .data1_o(q1[1]), .busy_o(bsy[1]), .illegal_o(ill[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                    output bit [2:0] c, output bit il);
        c  = 3'd0;
        il = 1'b0;
        if (op == 2'd1) c = 3'd1;
        else if (op == 2'd3) il = 1'b1;
        else if (op == 2'd2) begin
            case (f)
                6'b100000: c = 3'd0;
                6'b100010: c = 3'd1;
                6'b011000: c = 3'd2;
                6'b100100: c = 3'd3;
                6'b100101: c = 3'd4;
                default:   il = 1'b1;
            endcase
        end
    endfunction

    function automatic bit m_rdy(input int i);
        return (!m_v[i] && m_stall[i] == 0) || (m_v[i] && out_ready && m_code[i] != 3'd2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0; m_code[i] = 0; m_d0[i] = 0; m_d1[i] = 0; m_il[i] = 0; m_stall[i] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit acc, cons;
            acc  = in_valid && m_rdy(i);
            cons = m_v[i] && out_ready;
            if (m_stall[i] > 0) m_stall[i]--;
            if (cons) begin
                m_v[i] = 0;
                if (m_code[i] == 3'd2) m_stall[i] = lat[i] - 1;
            end
            if (acc) begin
                ref_dec(aluop, funct, m_code[i], m_il[i]);
                m_d0[i] = d0_in;
                m_d1[i] = d1_in;
                m_v[i]  = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, 32'(rdy[i]), 32'(m_rdy(i)));
            chk("out_valid", i, 32'(ov[i]), 32'(m_v[i]));
            chk("aluctrl", i, 32'(ctrl[i]), 32'(m_code[i]));
            chk("data0", i, q0[i], m_d0[i]);
            chk("data1", i, q1[i], m_d1[i]);
            chk("busy", i, 32'(bsy[i]), 32'(m_stall[i] > 0));
            chk("illegal", i, 32'(ill[i]), 32'(ILL_EN && m_v[i] && m_il[i]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_reset_vals(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_ov"}, i, 32'(ov[i]), 0);
            chk({nm, "_ctrl"}, i, 32'(ctrl[i]), 0);
            chk({nm, "_d0"}, i, q0[i], 0);
            chk({nm, "_d1"}, i, q1[i], 0);
            chk({nm, "_busy"}, i, 32'(bsy[i]), 0);
            chk({nm, "_ill"}, i, 32'(ill[i]), 0);
            chk({nm, "_rdy"}, i, 32'(rdy[i]), 1);
        end
    endtask

    initial begin
        logic [5:0] b2b_funct [4];
        logic [2:0] b2b_code [4];
        logic [5:0] fpick [6];
        b2b_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
        b2b_code  = '{3'b000, 3'b001, 3'b011, 3'b100};
        fpick     = '{6'b100000, 6'b100010, 6'b011000, 6'b100100, 6'b100101, 6'b000111};
        lat[0] = LAT0;
        lat[1] = LAT1;
        model_reset();

        #2 rst_i = 1'b1;
        #2 chk_reset_vals("por");
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;

        // back-to-back R-type stream, no bubbles
        in_valid = 1'b1; out_ready = 1'b1; aluop = 2'b10; d0_in = 32'd7; d1_in = 32'd3;
        for (int k = 0; k < 4; k++) begin
            funct = b2b_funct[k];
            step();
            chk("b2b_code", 0, 32'(ctrl[0]), 32'(b2b_code[k]));
            chk("b2b_valid", 0, 32'(ov[0]), 1);
            chk("b2b_d0", 0, q0[0], 32'd7);
            chk("b2b_d1", 0, q1[0], 32'd3);
        end
        drain(1);

        // MUL stall with an ADD offered continuously
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b011000; d0_in = 32'd5; d1_in = 32'd6;
        step();
        aluop = 2'b00; funct = 6'b0; d0_in = 32'd11;
        step();
        chk("mul_busy_m0", 0, 32'(bsy[0]), 1);
        chk("mul_rdy_m0", 0, 32'(rdy[0]), 0);
        chk("lat1_busy_m0", 1, 32'(bsy[1]), 0);
        chk("lat1_rdy_m0", 1, 32'(rdy[1]), 1);
        step();
        chk("mul_busy_m1", 0, 32'(bsy[0]), 1);
        chk("lat1_add_valid", 1, 32'(ov[1]), 1);
        step();
        chk("mul_busy_m2", 0, 32'(bsy[0]), 0);
        chk("mul_rdy_m2", 0, 32'(rdy[0]), 1);
        step();
        chk("mul_add_valid", 0, 32'(ov[0]), 1);
        chk("mul_add_code", 0, 32'(ctrl[0]), 0);
        chk("mul_add_d0", 0, q0[0], 32'd11);
        drain(2);

        // backpressure on a SUB beat
        in_valid = 1'b1; out_ready = 1'b0; aluop = 2'b01; d0_in = 32'h1234; d1_in = 32'h55;
        step();
        d0_in = 32'hdead; d1_in = 32'hbeef; aluop = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_code", 0, 32'(ctrl[0]), 32'd1);
            chk("bp_d0", 0, q0[0], 32'h1234);
            chk("bp_rdy", 0, 32'(rdy[0]), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_code", 0, 32'(ctrl[0]), 0);
        chk("bp_next_d0", 0, q0[0], 32'hdead);
        chk("bp_next_valid", 0, 32'(ov[0]), 1);
        drain(1);

        // undecodable funct, then a legal beat
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b000111; d0_in = 32'd9;
        step();
        chk("ill_code", 0, 32'(ctrl[0]), 0);
        chk("ill_flag", 0, 32'(ill[0]), 32'(ILL_EN));
        aluop = 2'b00; funct = 6'b100000;
        step();
        chk("ill_clear", 0, 32'(ill[0]), 0);
        drain(1);
        chk("ill_idle", 0, 32'(ill[0]), 0);

        // MUL_LAT=1: MUL then OR with no stall
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b011000;
        step();
        funct = 6'b100101;
        step();
        chk("lat1_rdy", 1, 32'(rdy[1]), 1);
        chk("lat1_busy", 1, 32'(bsy[1]), 0);
        step();
        chk("lat1_or_code", 1, 32'(ctrl[1]), 32'd4);
        chk("lat1_or_valid", 1, 32'(ov[1]), 1);
        drain(4);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            aluop     = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
            funct     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fpick[$urandom_range(0, 5)];
            d0_in     = $urandom;
            d1_in     = $urandom;
            step();
        end
        drain(20);

        // reset asserted while dut0 is in its MUL stall
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b011000;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_busy", 0, 32'(bsy[0]), 1);
        rst_i = 1'b1;
        #2 chk_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_reset();
        chk_reset_vals("rst_rel");
        drain(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
